rx_axis_upsizer: RTL and testbench
==================================

RX_AXIS_UPSIZER -- requirements
Module: rx_axis_upsizer

Interface
REQ-001 SHALL have parameter M_DATA_WIDTH, default 64, output data width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter S_DATA_WIDTH, default 8, input data width in bits; only 8 is legal.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_tdata  input  8  input byte.
REQ-006 SHALL have port s_tstrb  input  1  input byte-valid qualifier.
REQ-007 SHALL have port s_tvalid  input  1  input beat valid.
REQ-008 SHALL have port s_tlast  input  1  input end of frame.
REQ-009 SHALL have port s_tready  output  1  block accepts input beat.
REQ-010 SHALL have port s_err  input  1  frame-error flag, sampled only on the s_tlast handshake cycle.
REQ-011 SHALL have port m_tdata  output  M_DATA_WIDTH  packed output word.
REQ-012 SHALL have port m_tstrb  output  M_DATA_WIDTH/8  per-byte-lane valid.
REQ-013 SHALL have port m_tvalid, m_tlast, m_tuser  output  1 each  output valid, end of frame, frame error (meaningful with m_tlast).
REQ-014 SHALL have port m_tready  input  1  downstream accepts output word.

Function
REQ-015 SHALL define an input handshake as s_tvalid & s_tready and an output handshake as m_tvalid & m_tready, both sampled at posedge clk.
REQ-016 SHALL pack bytes little-endian: the k-th accepted byte of a word goes to m_tdata[8k+7:8k] and s_tstrb goes to m_tstrb[k].
REQ-017 SHALL keep a lane counter 0..N-1 (N = M_DATA_WIDTH/8), incremented on each input handshake and cleared on word completion.
REQ-018 SHALL complete a word when the byte is accepted at lane N-1 or with s_tlast=1; lanes not written in a completed word have strb 0 and data 0.
REQ-019 SHALL hold the accumulating word in an accumulator register and the presented word in a separate output register.
REQ-020 SHALL assert s_tready = ~acc_full, where acc_full marks a completed word not yet moved to the output register.
REQ-021 SHALL move a completed word into the output register in the cycle it completes if the output register is empty or handshaking that cycle; otherwise it SHALL set acc_full and move it on the first cycle the output register frees.
REQ-022 SHALL give a latency of one cycle: m_tvalid rises on the clock edge following the completing input handshake when not back-pressured.
REQ-023 SHALL hold m_tdata, m_tstrb, m_tlast and m_tuser stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL set m_tlast=1 on the word completed by s_tlast, and m_tuser = s_err captured on that handshake; m_tuser=0 on non-last words.
REQ-025 SHALL ignore s_err outside an s_tlast handshake.
REQ-026 SHALL sustain one input byte per cycle with m_tready held high; no bubble at word boundaries.
REQ-027 SHALL treat s_tlast at lane N-1 as a single full word (all strb 1, m_tlast=1), never as an extra empty word.

Reset
REQ-028 SHALL on reset_n=0 asynchronously clear lane counter, acc_full, accumulator and output register; m_tvalid, m_tlast, m_tuser=0, m_tdata, m_tstrb=0, s_tready=1 one cycle after reset deassertion.
REQ-029 SHALL discard any partial frame on reset mid-frame; the first beat after reset starts lane 0 of a new frame.

Configuration
REQ-030 SHALL, with macro RX_UPSIZER_STATS_EN defined, add outputs pkt_count[31:0] and err_count[31:0], incremented on each output handshake with m_tlast=1 (err_count additionally requires m_tuser=1), wrapping at 2^32, reset to 0.
REQ-031 SHALL, without RX_UPSIZER_STATS_EN, omit those ports and counters entirely.

Structure
REQ-032 SHALL place lane count N, lane-index width ($clog2(N)) and the counter width constant in shared package rx_upsizer_pkg.
REQ-033 SHALL be a single module with no sub-modules; the stats counters stay in-line under the macro.

Verification
REQ-034 SHALL verify: 8 bytes 0x01..0x08, tlast on 8th, m_tready=1 -> one word 0x0807060504030201, strb 0xFF, tlast=1, tuser=0, one cycle after byte 8.
REQ-035 SHALL verify: 3-byte frame 0xAA,0xBB,0xCC with s_err=1 on last -> word 0x0000000000CCBBAA, strb 0x07, tlast=1, tuser=1.
REQ-036 SHALL verify: 16 back-to-back bytes, m_tready=0 for 10 cycles after first word -> s_tready drops after byte 16, both words delivered intact in order, no byte lost.
REQ-037 SHALL verify: 1-byte frame then 9-byte frame back-to-back -> words strb 0x01/tlast=1, 0xFF/tlast=0, 0x01/tlast=1.
REQ-038 SHALL verify: reset_n pulsed low after 5 bytes of a frame -> all outputs zero, next 8-byte frame emitted with correct lane alignment.
REQ-039 SHALL verify with RX_UPSIZER_STATS_EN: 4 frames, 1 with s_err=1 -> pkt_count=4, err_count=1.

Source files
------------

// File: rtl/rx_upsizer_pkg.sv
// Shared constants for the RX AXI-Stream byte-to-word upsizer.
// Holds the byte width, the default lane count and lane-index width, and the
// statistics counter width, plus helpers that derive lane geometry from a word width.
package rx_upsizer_pkg;

  localparam int BYTE_W           = 8;
  localparam int CNT_W            = 32;
  localparam int DEF_M_DATA_WIDTH = 64;
  localparam int N_LANES          = DEF_M_DATA_WIDTH / BYTE_W;
  localparam int LANE_IDX_W       = $clog2(N_LANES);

  function automatic int lanes_of(input int width);
    return width / BYTE_W;
  endfunction

  function automatic int lane_idx_w_of(input int width);
    return (width / BYTE_W > 1) ? $clog2(width / BYTE_W) : 1;
  endfunction

endpackage

// File: rtl/rx_axis_upsizer.sv
// Packs an 8-bit AXI-Stream into M_DATA_WIDTH words, little-endian by lane.
// Ports: clk, reset_n (async, active-low); s_* byte input with s_err frame-error
//   flag on the last beat; m_* word output (m_tuser = frame error on m_tlast word).
// Optional macro RX_UPSIZER_STATS_EN adds pkt_count/err_count frame counters.
module rx_axis_upsizer
  import rx_upsizer_pkg::*;
#(
  parameter int M_DATA_WIDTH = DEF_M_DATA_WIDTH,
  parameter int S_DATA_WIDTH = BYTE_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [S_DATA_WIDTH-1:0]   s_tdata,
  input  logic                      s_tstrb,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  input  logic                      s_err,
  output logic [M_DATA_WIDTH-1:0]   m_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_tstrb,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  output logic                      m_tuser,
  input  logic                      m_tready
`ifdef RX_UPSIZER_STATS_EN
  ,
  output logic [CNT_W-1:0]          pkt_count,
  output logic [CNT_W-1:0]          err_count
`endif
);

  localparam int N  = lanes_of(M_DATA_WIDTH);
  localparam int LW = lane_idx_w_of(M_DATA_WIDTH);

  logic [LW-1:0]           lane;
  logic [M_DATA_WIDTH-1:0] acc_data, word_data;
  logic [N-1:0]            acc_strb, word_strb;
  logic                    acc_full, acc_last, acc_err;
  logic                    in_hs, out_free, complete, load_out;

  assign s_tready = ~acc_full;
  assign in_hs    = s_tvalid & ~acc_full;
  // Output register can take a new word when empty or emptying this cycle.
  assign out_free = ~m_tvalid | m_tready;
  assign complete = in_hs & ((lane == LW'(N - 1)) | s_tlast);
  assign load_out = out_free & (acc_full | complete);

  // Accumulator contents with the incoming byte merged into its lane.
  always_comb begin
    word_data = acc_data;
    word_strb = acc_strb;
    word_data[lane*S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata;
    word_strb[lane] = s_tstrb;
  end

  // Accumulator: collects bytes; parks a completed word when the output is busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane     <= '0;
      acc_data <= '0;
      acc_strb <= '0;
      acc_last <= 1'b0;
      acc_err  <= 1'b0;
      acc_full <= 1'b0;
    end else if (acc_full) begin
      // No input is accepted while full, so only the drain case matters here.
      if (out_free) begin
        acc_full <= 1'b0;
        acc_data <= '0;
        acc_strb <= '0;
        acc_last <= 1'b0;
        acc_err  <= 1'b0;
      end
    end else if (complete) begin
      lane <= '0;
      if (out_free) begin
        acc_data <= '0;
        acc_strb <= '0;
      end else begin
        acc_data <= word_data;
        acc_strb <= word_strb;
        acc_last <= s_tlast;
        acc_err  <= s_tlast & s_err;
        acc_full <= 1'b1;
      end
    end else if (in_hs) begin
      acc_data <= word_data;
      acc_strb <= word_strb;
      lane     <= lane + 1'b1;
    end
  end

  // Output register: a parked word always takes priority over a bypassed one,
  // which cannot coexist anyway since input is stalled while parked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (load_out) begin
      m_tvalid <= 1'b1;
      if (acc_full) begin
        m_tdata <= acc_data;
        m_tstrb <= acc_strb;
        m_tlast <= acc_last;
        m_tuser <= acc_err;
      end else begin
        m_tdata <= word_data;
        m_tstrb <= word_strb;
        m_tlast <= s_tlast;
        m_tuser <= s_tlast & s_err;
      end
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef RX_UPSIZER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (m_tvalid & m_tready & m_tlast) begin
      pkt_count <= pkt_count + 1'b1;
      if (m_tuser) begin
        err_count <= err_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_axis_upsizer.sv
// Directed bench for rx_axis_upsizer with a byte-level packing model and scoreboard.
module tb_rx_axis_upsizer;
  import rx_upsizer_pkg::*;

  localparam int MW = 64;
  localparam int NL = MW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    s_tdata;
  logic          s_tstrb, s_tvalid, s_tlast, s_err;
  logic          s_tready;
  logic [MW-1:0] m_tdata;
  logic [NL-1:0] m_tstrb;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready;
`ifdef RX_UPSIZER_STATS_EN
  logic [31:0]   pkt_count, err_count;
`endif

  always #5 clk = ~clk;

  rx_axis_upsizer #(.M_DATA_WIDTH(MW), .S_DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_err(s_err),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready)
`ifdef RX_UPSIZER_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    logic        u;
  } word_t;

  word_t exp_q[$];
  word_t rx_log[$];

  // Model: bytes fill lanes in order; a word closes at the last lane or on tlast.
  logic [63:0] m_d = '0;
  logic [7:0]  m_s = '0;
  int          m_lane = 0;

  function automatic void model_clear();
    m_d = '0;
    m_s = '0;
    m_lane = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] d, input logic last, input logic err);
    word_t w;
    m_d[m_lane*8 +: 8] = d;
    m_s[m_lane] = 1'b1;
    m_lane++;
    if (m_lane == NL || last) begin
      w.d = m_d;
      w.s = m_s;
      w.l = last;
      w.u = last & err;
      exp_q.push_back(w);
      model_clear();
    end
  endfunction

  // Scoreboard and hold-stability checks, sampled on the falling edge.
  logic  hold_vld = 1'b0;
  word_t held;
  always @(negedge clk) begin
    word_t w;
    if (!reset_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_data", m_tdata, held.d);
        chk("hold_strb", m_tstrb, held.s);
        chk("hold_last_user", {m_tlast, m_tuser}, {held.l, held.u});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected no word", m_tdata);
        end else begin
          w = exp_q.pop_front();
          chk("word_data", m_tdata, w.d);
          chk("word_strb", m_tstrb, w.s);
          chk("word_last", m_tlast, w.l);
          chk("word_user", m_tuser, w.u);
        end
        w.d = m_tdata; w.s = m_tstrb; w.l = m_tlast; w.u = m_tuser;
        rx_log.push_back(w);
      end
      hold_vld = m_tvalid && !m_tready;
      held.d = m_tdata; held.s = m_tstrb; held.l = m_tlast; held.u = m_tuser;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic err);
    int n = 0;
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = 1'b1; s_tlast = last; s_err = err;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      total++;
      bad++;
      $display("FAIL s_tready_timeout: got 0 expected 1 within 100 cycles");
    end else begin
      model_byte(d, last, err);
    end
  endtask

  // Non-last beats carry s_err=1 as noise that must not reach m_tuser.
  task automatic send_seq(input logic [7:0] first, input int len, input logic err, input logic with_last);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) send_beat(first + 8'(i), with_last, err);
      else              send_beat(first + 8'(i), 1'b0, 1'b1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0; s_tdata = '0; s_tstrb = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending_words", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {m_tvalid, m_tlast, m_tuser, m_tstrb, s_tready}, {3'b000, 8'h00, 1'b1});
    chk({name, "_data"}, m_tdata, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0; s_tdata = '0; s_tstrb = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_err = 1'b0; s_tdata = '0; s_tstrb = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset_state");
`ifdef RX_UPSIZER_STATS_EN
    chk("reset_counts", {pkt_count, err_count}, 64'h0);
`endif

    // Full 8-byte frame, one-cycle latency.
    rx_log.delete();
    send_seq(8'h01, 8, 1'b0, 1'b1);
    chk("latency_before_edge", m_tvalid, 1'b0);
    idle();
    chk("latency_after_edge", m_tvalid, 1'b1);
    wait_empty();
    chk("full_frame_count", rx_log.size(), 1);
    if (rx_log.size() >= 1) begin
      chk("full_frame_data", rx_log[0].d, 64'h0807060504030201);
      chk("full_frame_flags", {rx_log[0].s, rx_log[0].l, rx_log[0].u}, {8'hFF, 1'b1, 1'b0});
    end

    // Short frame with error on the last byte.
    rx_log.delete();
    send_beat(8'hAA, 1'b0, 1'b1);
    send_beat(8'hBB, 1'b0, 1'b0);
    send_beat(8'hCC, 1'b1, 1'b1);
    idle();
    wait_empty();
    chk("short_frame_count", rx_log.size(), 1);
    if (rx_log.size() >= 1) begin
      chk("short_frame_data", rx_log[0].d, 64'h0000000000CCBBAA);
      chk("short_frame_flags", {rx_log[0].s, rx_log[0].l, rx_log[0].u}, {8'h07, 1'b1, 1'b1});
    end

    // 16 back-to-back bytes with the output stalled for 10 cycles after word 1.
    rx_log.delete();
    fork
      begin
        send_seq(8'h10, 16, 1'b0, 1'b1);
        idle();
        chk("stall_s_tready_low", s_tready, 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!m_tvalid && n < 100);
        chk("stall_first_word_seen", m_tvalid, 1'b1);
        m_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_empty();
    chk("stall_word_count", rx_log.size(), 2);
    if (rx_log.size() >= 2) begin
      chk("stall_word0", rx_log[0].d, 64'h1716151413121110);
      chk("stall_word1", rx_log[1].d, 64'h1F1E1D1C1B1A1918);
      chk("stall_flags", {rx_log[0].s, rx_log[0].l, rx_log[1].s, rx_log[1].l},
          {8'hFF, 1'b0, 8'hFF, 1'b1});
    end

    // 1-byte frame then 9-byte frame, back-to-back.
    rx_log.delete();
    send_seq(8'h30, 1, 1'b0, 1'b1);
    send_seq(8'h40, 9, 1'b0, 1'b1);
    idle();
    wait_empty();
    chk("b2b_word_count", rx_log.size(), 3);
    if (rx_log.size() >= 3) begin
      chk("b2b_w0", {rx_log[0].d, rx_log[0].s, 7'b0, rx_log[0].l}, {64'h30, 8'h01, 8'h01});
      chk("b2b_w1", {rx_log[1].d, rx_log[1].s, 7'b0, rx_log[1].l},
          {64'h4746454443424140, 8'hFF, 8'h00});
      chk("b2b_w2", {rx_log[2].d, rx_log[2].s, 7'b0, rx_log[2].l}, {64'h48, 8'h01, 8'h01});
    end

    // Reset mid-frame after 5 bytes, then a clean 8-byte frame.
    rx_log.delete();
    send_seq(8'h60, 5, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    exp_q.delete();
    #1;
    chk_outputs_zero("midframe_reset_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midframe_reset_release");
    send_seq(8'h50, 8, 1'b0, 1'b1);
    idle();
    wait_empty();
    chk("post_reset_count", rx_log.size(), 1);
    if (rx_log.size() >= 1) begin
      chk("post_reset_data", rx_log[0].d, 64'h5756555453525150);
      chk("post_reset_flags", {rx_log[0].s, rx_log[0].l}, {8'hFF, 1'b1});
    end

`ifdef RX_UPSIZER_STATS_EN
    do_reset();
    send_seq(8'h01, 3, 1'b0, 1'b1);
    send_seq(8'h11, 8, 1'b1, 1'b1);
    send_seq(8'h21, 10, 1'b0, 1'b1);
    send_seq(8'h31, 1, 1'b0, 1'b1);
    idle();
    wait_empty();
    chk("stats_pkt_count", pkt_count, 32'd4);
    chk("stats_err_count", err_count, 32'd1);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
